// File: rtl/mem_access_pkg.sv
// Shared types for the memory-stage data-bus engine: access sizes, bus request/response, FSM states.
package mem_access_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // Byte-lane enable pattern for a right-aligned access of the given size.
    function automatic strobe_t size_mask(msize_t size);
        unique case (size)
            MSIZE1:  return 8'h01;
            MSIZE2:  return 8'h03;
            MSIZE4:  return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    // True when the low address bits violate natural alignment for the size.
    function automatic logic misaligned(logic [2:0] off, msize_t size);
        unique case (size)
            MSIZE1:  return 1'b0;
            MSIZE2:  return off[0];
            MSIZE4:  return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational byte-lane alignment: store strobe/data shifting and load extraction with
// sign or zero extension.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  off,
    input  msize_t      size,
    input  logic        sext,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output strobe_t     strobe,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata_ext
);

    logic [5:0]  shamt;
    logic [63:0] raw;

    assign shamt    = {off, 3'b000};
    assign strobe   = size_mask(size) << off;
    assign wdata_sh = wdata << shamt;
    assign raw      = rdata >> shamt;

    always_comb begin
        rdata_ext = raw;
        unique case (size)
            MSIZE1:  rdata_ext = {{56{sext & raw[7]}},  raw[7:0]};
            MSIZE2:  rdata_ext = {{48{sext & raw[15]}}, raw[15:0]};
            MSIZE4:  rdata_ext = {{32{sext & raw[31]}}, raw[31:0]};
            default: rdata_ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage data-bus engine: one load/store per operation over the addr_ok/data_ok bus.
// Optional misaligned-address trap enabled by MEM_ACCESS_MISALIGN_CHECK_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_store,
    input  msize_t            in_size,
    input  logic              in_sext,
    output dbus_req_t         dreq,
    input  dbus_resp_t        dresp,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_rdata
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              store_q;
    msize_t            size_q;
    logic              sext_q;
    logic [DATA_W-1:0] rdata_q;

    logic              accept;
    logic              data_edge;
    logic              mis_now;
    strobe_t           strobe;
    logic [63:0]       wdata_sh;
    logic [63:0]       rdata_ext;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    logic mis_q;
    assign mis_now  = misaligned(in_addr[2:0], in_size);
    assign misalign = (state_q == DONE) & mis_q;
`else
    assign mis_now  = 1'b0;
`endif

    assign accept    = (state_q == IDLE) & in_valid;
    assign data_edge = ((state_q == REQ) & dresp.addr_ok & dresp.data_ok)
                     | ((state_q == WAIT) & dresp.data_ok);

    mem_align u_align (
        .off       (addr_q[2:0]),
        .size      (size_q),
        .sext      (sext_q),
        .wdata     (wdata_q),
        .rdata     (dresp.data),
        .strobe    (strobe),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = mis_now ? DONE : REQ;
            REQ:  if (dresp.addr_ok) state_d = dresp.data_ok ? DONE : WAIT;
            WAIT: if (dresp.data_ok) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields come only from latched state so they hold still until addr_ok.
    always_comb begin
        dreq        = '0;
        dreq.valid  = (state_q == REQ);
        dreq.addr   = addr_q;
        dreq.size   = size_q;
        dreq.strobe = store_q ? strobe : '0;
        dreq.data   = store_q ? wdata_sh : '0;
    end

    assign in_ready  = (state_q == IDLE);
    assign stall     = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_rdata = rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
            size_q  <= MSIZE1;
            sext_q  <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
                store_q <= in_store;
                size_q  <= in_size;
                sext_q  <= in_sext;
            end
            if (data_edge) begin
                rdata_q <= store_q ? '0 : rdata_ext;
            end
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
            if (accept) begin
                mis_q <= mis_now;
                if (mis_now) rdata_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access with a behavioural bus/alignment model.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic        in_store;
    msize_t      in_size;
    logic        in_sext;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        stall;
    logic        out_valid;
    logic [63:0] out_rdata;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   issued = 0;

    mem_access dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_store  (in_store),
        .in_size   (in_size),
        .in_sext   (in_sext),
        .dreq      (dreq),
        .dresp     (dresp),
        .stall     (stall),
        .out_valid (out_valid),
        .out_rdata (out_rdata)
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        ,
        .misalign  (misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] m_strobe(input logic [2:0] off, input int size);
        int m;
        m = ((1 << (1 << size)) - 1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] bus, input logic [2:0] off,
                                           input int size, input logic sx);
        int          bits;
        logic [63:0] v;
        logic [63:0] mask;
        bits = 8 << size;
        v    = bus >> (8 * off);
        if (bits < 64) begin
            mask = (64'd1 << bits) - 64'd1;
            v    = v & mask;
            if (sx && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // Monitor: every completion pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                chk("out_rdata", out_rdata, mon_e.rdata);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
                chk("misalign", misalign, mon_e.mis);
`endif
            end
        end
    end

    // Issue one operation and play the bus slave with addr_ok after adly cycles and
    // data_ok ddly cycles after that (0 = same cycle).
    task automatic do_op(input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] bus, input logic st, input int size,
                         input logic sx, input int adly, input int ddly);
        logic [7:0]  es;
        logic [63:0] ed;
        exp_t        e;
        int          guard;
        es = st ? m_strobe(addr[2:0], size) : 8'h00;
        ed = st ? (wdata << (8 * addr[2:0])) : 64'h0;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
            return;
        end
        in_addr  = addr;
        in_wdata = wdata;
        in_store = st;
        in_size  = msize_t'(size);
        in_sext  = sx;
        in_valid = 1'b1;
        e.rdata  = st ? 64'h0 : m_load(bus, addr[2:0], size, sx);
        e.mis    = 1'b0;
        sb.push_back(e);
        issued++;
        @(negedge clk);
        for (int i = 0; i <= adly; i++) begin
            chk("req_valid", dreq.valid, 1);
            chk("req_addr", dreq.addr, addr);
            chk("req_size", dreq.size, size);
            chk("req_strobe", dreq.strobe, es);
            chk("req_data", dreq.data, ed);
            chk("stall_req", stall, 1);
            // Noise on the inputs while busy must be ignored.
            in_valid   = (i < adly);
            in_addr    = {$urandom, $urandom};
            in_wdata   = {$urandom, $urandom};
            in_store   = 1'($urandom);
            in_size    = msize_t'($urandom_range(0, 3));
            dresp.addr_ok = (i == adly);
            dresp.data_ok = (i == adly) && (ddly == 0);
            dresp.data    = ((i == adly) && (ddly == 0)) ? bus : {$urandom, $urandom};
            @(negedge clk);
        end
        for (int i = 1; i <= ddly; i++) begin
            chk("wait_valid", dreq.valid, 0);
            chk("stall_wait", stall, 1);
            chk("wait_no_out", out_valid, 0);
            dresp.addr_ok = 1'b0;
            dresp.data_ok = (i == ddly);
            dresp.data    = (i == ddly) ? bus : {$urandom, $urandom};
            @(negedge clk);
        end
        chk("done_out_valid", out_valid, 1);
        chk("done_req_valid", dreq.valid, 0);
        dresp = '0;
        @(negedge clk);
        chk("pulse_single", out_valid, 0);
        chk("idle_ready", in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        int          sz;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_wdata = '0;
        in_store = 1'b0;
        in_size  = MSIZE1;
        in_sext  = 1'b0;
        dresp    = '0;
        repeat (2) @(negedge clk);
        chk("rst_dreq_valid", dreq.valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rdata", out_rdata, 0);
        chk("rst_strobe", dreq.strobe, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b1;
        @(negedge clk);

        do_op(64'h8000_1004, 64'hDEAD_BEEF, 64'h1234_5678_9abc_def0, 1'b1, 2, 1'b0, 0, 0);
        do_op(64'h8000_2007, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 0, 1'b1, 0, 0);
        do_op(64'h8000_3002, 64'h0, 64'h0000_0000_BEEF_0000, 1'b0, 1, 1'b0, 1, 0);
        do_op(64'h8000_3010, 64'h0, 64'hFFFF_FFFF_8765_4321, 1'b0, 2, 1'b1, 3, 4);
        do_op(64'h8000_3018, 64'hCAFE_F00D_1234_5678, 64'h0, 1'b1, 3, 1'b0, 3, 4);

        for (int n = 0; n < 40; n++) begin
            sz = $urandom_range(0, 3);
            a  = {$urandom, $urandom};
            a  = a & ~((64'd1 << sz) - 64'd1);
            do_op(a, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), sz,
                  1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset mid-access in WAIT: request and stall drop at once, nothing completes.
        in_addr  = 64'h8000_5008;
        in_store = 1'b0;
        in_size  = MSIZE8;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid      = 1'b0;
        dresp.addr_ok = 1'b1;
        @(negedge clk);
        dresp = '0;
        @(negedge clk);
        chk("wait_before_rst", stall, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_valid", dreq.valid, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_out", out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op(64'h8000_6004, 64'h0, 64'h0000_7FFF_0000_0000, 1'b0, 1, 1'b1, 1, 2);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        begin
            exp_t e;
            in_addr  = 64'h8000_7002;
            in_store = 1'b0;
            in_size  = MSIZE4;
            in_sext  = 1'b0;
            in_valid = 1'b1;
            e.rdata  = 64'h0;
            e.mis    = 1'b1;
            sb.push_back(e);
            issued++;
            @(negedge clk);
            in_valid = 1'b0;
            chk("mis_out_valid", out_valid, 1);
            chk("mis_no_req", dreq.valid, 0);
            @(negedge clk);
            chk("mis_back_idle", in_ready, 1);
        end
`endif

        repeat (3) @(negedge clk);
        chk("pulse_count", pulses, issued);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
